kernel_gemm_seq: RTL and testbench
==================================

# kernel_gemm_seq

Parametrised call/return control sequencer for matrix-multiply kernels: the next generation of the fixed-shape 2mm component interface. It accepts one invocation (scalars plus base addresses plus runtime dimensions) over the call handshake. It walks the full i/j/k loop nest and emits one element-address step per cycle on a valid/ready stream to the MAC datapath, then signals completion on the return handshake. A single instance serves either GEMM stage of a 2mm pipeline; dimensions are runtime, not synthesis constants.

## Interface
- ADDR_W, 64, width of base addresses and step addresses
- DATA_W, 32, width of alpha/beta scalars
- DIM_W, 16, width of ni/nj/nk
- ELEM_BYTES, 4, element size in bytes (power of two)

- clock  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  call.valid
- busy  out  1  call.stall; high whenever state != IDLE
- done  out  1  return.valid
- stall  in  1  return.stall
- alpha, beta  in  DATA_W  scalars, latched at call accept
- A, B, C  in  ADDR_W  base addresses, latched at call accept
- ni, nj, nk  in  DIM_W  loop bounds, latched at call accept
- alpha_q, beta_q  out  DATA_W  latched scalars, stable IDLE-exit to next accept
- step_valid  out  1  step available
- step_ready  in  1  datapath accepts step
- step_a_addr, step_b_addr, step_c_addr  out  ADDR_W  element addresses
- step_first  out  1  k == 0 (datapath initialises accumulator)
- step_last  out  1  k == nk-1 (datapath writes C[i][j])

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0. start=1 -> accept call: latch all inputs, clear i=j=k=0. If any of ni/nj/nk is 0 go to DONE, else RUN.
- RUN: step_valid=1 with addresses for current (i,j,k). On step_valid && step_ready advance k; k wraps at nk and increments j; j wraps at nj and increments i. Accepting step (ni-1,nj-1,nk-1) -> DONE.
- Order: i outer, j middle, k inner; total ni*nj*nk steps, row-major.
- step_a_addr = A + (i*nk + k)*ELEM_BYTES; step_b_addr = B + (k*nj + j)*ELEM_BYTES; step_c_addr = C + (i*nj + j)*ELEM_BYTES; all modulo 2^ADDR_W. Products formed at DIM_W*2 bits before scaling. Implementation uses incremental row-base adders, no runtime multipliers; results must equal the formulas bit-exactly.
- step_* outputs hold stable while step_valid && !step_ready.
- DONE: done=1 held until cycle with stall=0; that cycle completes return, next state IDLE.
- start while busy=1 is ignored, not queued.
- Reset (any state, any time): state IDLE, all outputs 0, counters cleared; in-flight steps are discarded with no done.

## Timing
- Call accepted at cycle t (start=1, busy=0): busy=1 and step_valid=1 from t+1.
- Steady state 1 step/cycle with step_ready held high; no bubbles at k or j wrap.
- Last step accepted at cycle u: step_valid=0, done=1 at u+1.
- Zero dimension accepted at t: done=1 at t+1, no step_valid ever.
- done && !stall at cycle v: done=0, busy=0 at v+1; a new start at v+1 is accepted.
- All outputs registered; no combinational path from step_ready or stall to any output.

## Configuration
- KERNEL_GEMM_PERF_EN defined: adds outputs perf_cycles (32) and perf_stalls (32). Both clear on call accept. perf_cycles increments each cycle in RUN. perf_stalls increments each cycle with step_valid && !step_ready. Both hold after DONE until next accept and saturate at 2^32-1. Reset value 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- ni=2,nj=3,nk=4, A=0x1000,B=0x2000,C=0x3000, ready=1 -> 24 back-to-back steps. Step 0: A/B/C = 0x1000/0x2000/0x3000, first=1. Step 23: 0x101C/0x202C/0x3014, last=1. done at cycle after step 23.
- Same call, step_ready toggled 1,0,0,1,... -> addresses stable across stalls, same 24-step sequence; perf_stalls equals the count of ready-low cycles while valid (PERF_EN build).
- nk=0 -> done at t+1, zero steps. Hold stall=1 for 5 cycles -> done held for 5 cycles, busy=1, start ignored; stall=0 -> busy=0 next cycle.
- A=0xFFFF_FFFF_FFFF_FFF8, ni=nj=1, nk=4 -> step_a_addr wraps: ...FFF8, ...FFFC, 0x0, 0x4.
- resetn pulsed low mid-RUN at step 10 -> outputs 0 immediately, busy=0. Next call starts at step 0 with freshly latched args.
- ni=nj=nk=1, then a second start on the cycle after the return completes -> exactly one step per call, done pulses twice, alpha_q/beta_q update at each accept.

Source files
------------

// File: rtl/kernel_gemm_seq.sv
// Call/return sequencer that walks a runtime-sized GEMM i/j/k loop nest and streams element addresses.
// Optional cycle/stall counters are built when KERNEL_GEMM_PERF_EN is defined.
module kernel_gemm_seq #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 32,
  parameter int DIM_W      = 16,
  parameter int ELEM_BYTES = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              stall,
  input  logic [DATA_W-1:0] alpha,
  input  logic [DATA_W-1:0] beta,
  input  logic [ADDR_W-1:0] A,
  input  logic [ADDR_W-1:0] B,
  input  logic [ADDR_W-1:0] C,
  input  logic [DIM_W-1:0]  ni,
  input  logic [DIM_W-1:0]  nj,
  input  logic [DIM_W-1:0]  nk,
  output logic [DATA_W-1:0] alpha_q,
  output logic [DATA_W-1:0] beta_q,
`ifdef KERNEL_GEMM_PERF_EN
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls,
`endif
  output logic              step_valid,
  input  logic              step_ready,
  output logic [ADDR_W-1:0] step_a_addr,
  output logic [ADDR_W-1:0] step_b_addr,
  output logic [ADDR_W-1:0] step_c_addr,
  output logic              step_first,
  output logic              step_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] EB = ADDR_W'(ELEM_BYTES);
  localparam int                SH = $clog2(ELEM_BYTES);

  state_t             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic               first_q, first_d, last_q, last_d;
  logic [DATA_W-1:0]  alpha_lat_q, alpha_lat_d, beta_lat_q, beta_lat_d;
  logic [DIM_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DIM_W-1:0]   ni_m1_q, ni_m1_d, nj_m1_q, nj_m1_d, nk_m1_q, nk_m1_d;
  logic [ADDR_W-1:0]  a_q, a_d, a_row_q, a_row_d;
  logic [ADDR_W-1:0]  b_q, b_d, b_col_q, b_col_d, b_base_q, b_base_d, b_stride_q, b_stride_d;
  logic [ADDR_W-1:0]  c_q, c_d;
  logic               k_wrap, j_wrap, i_wrap;

  assign k_wrap = (k_q == nk_m1_q);
  assign j_wrap = (j_q == nj_m1_q);
  assign i_wrap = (i_q == ni_m1_q);

  // Addresses advance by strength-reduced adds: a_row tracks A+i*nk, b_col tracks B+j.
  // NOTE: every next-state variable is defaulted to its current value first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    valid_d    = valid_q;
    first_d    = first_q;
    last_d     = last_q;
    alpha_lat_d = alpha_lat_q;
    beta_lat_d = beta_lat_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    ni_m1_d    = ni_m1_q;
    nj_m1_d    = nj_m1_q;
    nk_m1_d    = nk_m1_q;
    a_d        = a_q;
    a_row_d    = a_row_q;
    b_d        = b_q;
    b_col_d    = b_col_q;
    b_base_d   = b_base_q;
    b_stride_d = b_stride_q;
    c_d        = c_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          alpha_lat_d = alpha;
          beta_lat_d  = beta;
          i_d         = '0;
          j_d         = '0;
          k_d         = '0;
          ni_m1_d     = ni - DIM_W'(1);
          nj_m1_d     = nj - DIM_W'(1);
          nk_m1_d     = nk - DIM_W'(1);
          a_d         = A;
          a_row_d     = A;
          b_d         = B;
          b_col_d     = B;
          b_base_d    = B;
          b_stride_d  = ADDR_W'(nj) << SH;
          c_d         = C;
          first_d     = 1'b1;
          last_d      = (nk == DIM_W'(1));
          busy_d      = 1'b1;
          if (ni == '0 || nj == '0 || nk == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end else begin
            state_d = S_RUN;
            valid_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (step_ready) begin
          if (k_wrap && j_wrap && i_wrap) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (!k_wrap) begin
            k_d     = k_q + DIM_W'(1);
            a_d     = a_q + EB;
            b_d     = b_q + b_stride_q;
            first_d = 1'b0;
            last_d  = (k_q + DIM_W'(1) == nk_m1_q);
          end else begin
            k_d     = '0;
            first_d = 1'b1;
            last_d  = (nk_m1_q == '0);
            c_d     = c_q + EB;
            if (!j_wrap) begin
              j_d     = j_q + DIM_W'(1);
              a_d     = a_row_q;
              b_col_d = b_col_q + EB;
              b_d     = b_col_q + EB;
            end else begin
              // The element after A[i][nk-1] is A[i+1][0], so the new row base is one step on.
              j_d     = '0;
              i_d     = i_q + DIM_W'(1);
              a_d     = a_q + EB;
              a_row_d = a_q + EB;
              b_col_d = b_base_q;
              b_d     = b_base_q;
            end
          end
        end
      end
      S_DONE: begin
        if (!stall) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      alpha_lat_q <= '0;
      beta_lat_q  <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      ni_m1_q     <= '0;
      nj_m1_q     <= '0;
      nk_m1_q     <= '0;
      a_q         <= '0;
      a_row_q     <= '0;
      b_q         <= '0;
      b_col_q     <= '0;
      b_base_q    <= '0;
      b_stride_q  <= '0;
      c_q         <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      alpha_lat_q <= alpha_lat_d;
      beta_lat_q  <= beta_lat_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      ni_m1_q     <= ni_m1_d;
      nj_m1_q     <= nj_m1_d;
      nk_m1_q     <= nk_m1_d;
      a_q         <= a_d;
      a_row_q     <= a_row_d;
      b_q         <= b_d;
      b_col_q     <= b_col_d;
      b_base_q    <= b_base_d;
      b_stride_q  <= b_stride_d;
      c_q         <= c_d;
    end
  end

`ifdef KERNEL_GEMM_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (state_q == S_RUN && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (valid_q && !step_ready && perf_stalls_q != '1) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign step_valid  = valid_q;
  assign step_first  = first_q;
  assign step_last   = last_q;
  assign step_a_addr = a_q;
  assign step_b_addr = b_q;
  assign step_c_addr = c_q;
  assign alpha_q     = alpha_lat_q;
  assign beta_q      = beta_lat_q;

endmodule

// File: tb/tb_kernel_gemm_seq.sv
// Self-checking bench for kernel_gemm_seq: directed calls plus random dimensions, addresses and ready patterns.
// Expected steps come from a nested-loop model of the GEMM address formulas.
module tb_kernel_gemm_seq;
  localparam int EB = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        step_ready = 1'b0;
  logic [31:0] alpha = '0, beta = '0;
  logic [63:0] A = '0, B = '0, C = '0;
  logic [15:0] ni = '0, nj = '0, nk = '0;
  logic        busy, done, step_valid, step_first, step_last;
  logic [31:0] alpha_q, beta_q;
  logic [63:0] step_a_addr, step_b_addr, step_c_addr;
`ifdef KERNEL_GEMM_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic        first;
    logic        last;
  } step_t;

  step_t exp_q[$];

  kernel_gemm_seq dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .stall       (stall),
    .alpha       (alpha),
    .beta        (beta),
    .A           (A),
    .B           (B),
    .C           (C),
    .ni          (ni),
    .nj          (nj),
    .nk          (nk),
    .alpha_q     (alpha_q),
    .beta_q      (beta_q),
`ifdef KERNEL_GEMM_PERF_EN
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls),
`endif
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .step_a_addr (step_a_addr),
    .step_b_addr (step_b_addr),
    .step_c_addr (step_c_addr),
    .step_first  (step_first),
    .step_last   (step_last)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic build_model(input int n_i, input int n_j, input int n_k,
                             input logic [63:0] a0, input logic [63:0] b0, input logic [63:0] c0);
    step_t s;
    exp_q.delete();
    for (int i = 0; i < n_i; i++)
      for (int j = 0; j < n_j; j++)
        for (int k = 0; k < n_k; k++) begin
          s.a     = a0 + 64'(i * n_k + k) * 64'(EB);
          s.b     = b0 + 64'(k * n_j + j) * 64'(EB);
          s.c     = c0 + 64'(i * n_j + j) * 64'(EB);
          s.first = (k == 0);
          s.last  = (k == n_k - 1);
          exp_q.push_back(s);
        end
  endtask

  // Called at a negedge with the DUT idle. mode: 0 ready high, 1 ready 1,0,0 pattern, 2 random.
  // abort_at >= 0 returns after that many accepted steps, leaving the call in flight.
  task automatic do_call(input int n_i, input int n_j, input int n_k,
                         input logic [63:0] a0, input logic [63:0] b0, input logic [63:0] c0,
                         input int mode, input int hold_cycles, input int abort_at);
    logic [31:0] al, be;
    logic        rdy;
    int          idx = 0, cyc = 0, stalls_seen = 0;
    build_model(n_i, n_j, n_k, a0, b0, c0);
    check("busy_before_call", busy, 1'b0);
    al = $urandom; be = $urandom;
    alpha = al; beta = be; A = a0; B = b0; C = c0;
    ni = 16'(n_i); nj = 16'(n_j); nk = 16'(n_k);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    alpha = $urandom; beta = $urandom; A = {$urandom, $urandom}; B = {$urandom, $urandom};
    C = {$urandom, $urandom}; ni = 16'($urandom); nj = 16'($urandom); nk = 16'($urandom);
    check("busy_after_accept", busy, 1'b1);
    check("alpha_latched", alpha_q, al);
    check("beta_latched", beta_q, be);
    while (idx < exp_q.size() && cyc < 4096) begin
      if (abort_at >= 0 && idx == abort_at) return;
      check("step_valid", step_valid, 1'b1);
      check("step_a_addr", step_a_addr, exp_q[idx].a);
      check("step_b_addr", step_b_addr, exp_q[idx].b);
      check("step_c_addr", step_c_addr, exp_q[idx].c);
      check("step_first", step_first, exp_q[idx].first);
      check("step_last", step_last, exp_q[idx].last);
      check("done_during_run", done, 1'b0);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      step_ready = rdy;
      if (!rdy) stalls_seen++;
      @(negedge clock);
      if (rdy) idx++;
      cyc++;
    end
    step_ready = 1'b0;
    check("all_steps_accepted", 64'(idx), 64'(exp_q.size()));
    check("valid_after_last", step_valid, 1'b0);
    check("done_after_last", done, 1'b1);
    check("busy_in_done", busy, 1'b1);
`ifdef KERNEL_GEMM_PERF_EN
    check("perf_cycles", perf_cycles, 64'(cyc));
    check("perf_stalls", perf_stalls, 64'(stalls_seen));
`endif
    stall = 1'b1;
    for (int h = 0; h < hold_cycles; h++) begin
      start = 1'b1;
      alpha = $urandom; ni = 16'd1; nj = 16'd1; nk = 16'd1;
      @(negedge clock);
      check("done_held", done, 1'b1);
      check("busy_held", busy, 1'b1);
      check("no_step_in_done", step_valid, 1'b0);
    end
    start = 1'b0;
    stall = 1'b0;
    @(negedge clock);
    check("done_cleared", done, 1'b0);
    check("busy_cleared", busy, 1'b0);
    check("alpha_not_relatched", alpha_q, al);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_valid", step_valid, 1'b0);
    check("reset_a_addr", step_a_addr, 64'h0);
    check("reset_alpha_q", alpha_q, 32'h0);
    resetn = 1'b1;
    @(negedge clock);

    do_call(2, 3, 4, 64'h1000, 64'h2000, 64'h3000, 0, 0, -1);
    do_call(2, 3, 4, 64'h1000, 64'h2000, 64'h3000, 1, 0, -1);
    do_call(2, 3, 0, 64'h1000, 64'h2000, 64'h3000, 0, 5, -1);
    do_call(1, 1, 4, 64'hFFFF_FFFF_FFFF_FFF8, 64'h40, 64'h80, 0, 0, -1);

    do_call(4, 4, 4, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 10);
    resetn = 1'b0;
    #1;
    check("midrun_reset_busy", busy, 1'b0);
    check("midrun_reset_valid", step_valid, 1'b0);
    check("midrun_reset_done", done, 1'b0);
    check("midrun_reset_a", step_a_addr, 64'h0);
    check("midrun_reset_c", step_c_addr, 64'h0);
    check("midrun_reset_alpha", alpha_q, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("post_reset_no_done", done, 1'b0);
    do_call(3, 2, 2, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 2, 1, -1);

    do_call(1, 1, 1, 64'h100, 64'h200, 64'h300, 0, 0, -1);
    do_call(1, 1, 1, 64'h500, 64'h600, 64'h700, 0, 0, -1);

    for (int r = 0; r < 8; r++)
      do_call($urandom_range(0, 4), $urandom_range(1, 4), $urandom_range(1, 5),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              2, $urandom_range(0, 3), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
